// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory port between the core (m0) and a debug/DMA loader (m1).
// Define MEM_ARB_TIMEOUT_EN to bound locked bursts to MAX_LOCK grants while the other side waits.
`timescale 1ns/1ps

module dmem_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_LOCK = 16
) (
   input  logic          clk,
   input  logic          areset,

   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic          m0_lock,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,

   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   input  logic          m1_lock,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,

   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rd,

   output logic [1:0]    owner,
   output logic          lock_err
);

   // state  | meaning
   // IDLE   | no owner; port muxed to m0, writes disabled
   // OWN0   | m0 owns the port; m0_gnt follows m0_req
   // OWN1   | m1 owns the port; m1_gnt follows m1_req
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_OWN0 = 2'b01,
      S_OWN1 = 2'b10
   } state_t;

   state_t state;
   logic   last;
   logic   rd0;
   logic   rd1;

   if (MAX_LOCK < 2) begin : g_bad_max_lock
      $error("dmem_arbiter: MAX_LOCK must be at least 2");
   end

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(MAX_LOCK);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK - 1);
   logic [CW-1:0] lock_cnt;
`else
   assign lock_err = 1'b0;
`endif

   // Grants are gated by reset so nothing reaches memory while the FSM state is stale.
   assign m0_gnt   = ~areset & (state == S_OWN0) & m0_req;
   assign m1_gnt   = ~areset & (state == S_OWN1) & m1_req;
   assign rd0      = m0_gnt & ~m0_we;
   assign rd1      = m1_gnt & ~m1_we;

   assign mem_addr = (state == S_OWN1) ? m1_addr  : m0_addr;
   assign mem_wd   = (state == S_OWN1) ? m1_wdata : m0_wdata;
   assign mem_we   = (m0_gnt & m0_we) | (m1_gnt & m1_we);
   assign owner    = state;

   always_ff @(posedge clk) begin
      if (areset) begin
         state     <= S_IDLE;
         last      <= 1'b1;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         lock_cnt  <= '0;
         lock_err  <= 1'b0;
`endif
      end else begin
         m0_rvalid <= rd0;
         m1_rvalid <= rd1;
         if (rd0) m0_rdata <= mem_rd;
         if (rd1) m1_rdata <= mem_rd;
`ifdef MEM_ARB_TIMEOUT_EN
         lock_err  <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
               lock_cnt <= '0;
`endif
               if (m0_req && (!m1_req || last)) begin
                  state <= S_OWN0;
                  last  <= 1'b0;
               end else if (m1_req) begin
                  state <= S_OWN1;
                  last  <= 1'b1;
               end
            end

            S_OWN0: begin
               if (m0_req && m0_lock) begin
`ifdef MEM_ARB_TIMEOUT_EN
                  if (m1_req && lock_cnt == CNT_MAX) begin
                     state    <= S_OWN1;
                     last     <= 1'b1;
                     lock_cnt <= '0;
                     lock_err <= 1'b1;
                  end else if (lock_cnt != CNT_MAX) begin
                     lock_cnt <= lock_cnt + 1'b1;
                  end
`else
                  state <= S_OWN0;
`endif
               end else begin
`ifdef MEM_ARB_TIMEOUT_EN
                  lock_cnt <= '0;
`endif
                  if (m1_req) begin
                     state <= S_OWN1;
                     last  <= 1'b1;
                  end else if (!m0_req) begin
                     state <= S_IDLE;
                  end
               end
            end

            S_OWN1: begin
               if (m1_req && m1_lock) begin
`ifdef MEM_ARB_TIMEOUT_EN
                  if (m0_req && lock_cnt == CNT_MAX) begin
                     state    <= S_OWN0;
                     last     <= 1'b0;
                     lock_cnt <= '0;
                     lock_err <= 1'b1;
                  end else if (lock_cnt != CNT_MAX) begin
                     lock_cnt <= lock_cnt + 1'b1;
                  end
`else
                  state <= S_OWN1;
`endif
               end else begin
`ifdef MEM_ARB_TIMEOUT_EN
                  lock_cnt <= '0;
`endif
                  if (m0_req) begin
                     state <= S_OWN0;
                     last  <= 1'b0;
                  end else if (!m1_req) begin
                     state <= S_IDLE;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: drivers issue queued transactions, a negedge monitor
// pops expected grants, read returns and lock_err pulses and compares them.
`timescale 1ns/1ps

module tb_dmem_arbiter;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        lock;
   } txn_t;

   typedef struct {
      int          cyc;
      int          port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
   } eg_t;

   typedef struct {
      int          cyc;
      int          port;
      logic [31:0] data;
   } er_t;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic EXP_LERR = 1'b1;
`else
   localparam logic EXP_LERR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        areset;
   logic [1:0]  raw_req;
   logic        d0_req, d1_req;
   txn_t        d0, d1;
   logic        flush0, flush1;

   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wd, mem_rd;
   logic [1:0]  owner;
   logic        lock_err;

   logic [31:0] mem [0:1023];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   txn_t        q0[$];
   txn_t        q1[$];
   eg_t         exp_gnt[$];
   er_t         exp_rd[$];
   int          exp_lerr[$];
   eg_t         mon_g;
   er_t         mon_r;

   dmem_arbiter #(.AW(32), .DW(32), .MAX_LOCK(4)) dut (
      .clk       (clk),
      .areset    (areset),
      .m0_req    (d0_req | raw_req[0]),
      .m0_we     (d0.we),
      .m0_addr   (d0.addr),
      .m0_wdata  (d0.wd),
      .m0_lock   (d0.lock),
      .m0_gnt    (m0_gnt),
      .m0_rvalid (m0_rvalid),
      .m0_rdata  (m0_rdata),
      .m1_req    (d1_req | raw_req[1]),
      .m1_we     (d1.we),
      .m1_addr   (d1.addr),
      .m1_wdata  (d1.wd),
      .m1_lock   (d1.lock),
      .m1_gnt    (m1_gnt),
      .m1_rvalid (m1_rvalid),
      .m1_rdata  (m1_rdata),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wd    (mem_wd),
      .mem_rd    (mem_rd),
      .owner     (owner),
      .lock_err  (lock_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign mem_rd = mem[mem_addr[11:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int m, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic lk);
      txn_t t;
      t.we = we; t.addr = a; t.wd = wd; t.lock = lk;
      if (m == 0) q0.push_back(t); else q1.push_back(t);
   endtask

   task automatic exp_g(input int c, input int p, input logic we,
                        input logic [31:0] a, input logic [31:0] wd);
      eg_t g;
      g.cyc = c; g.port = p; g.we = we; g.addr = a; g.wd = wd;
      exp_gnt.push_back(g);
   endtask

   task automatic exp_r(input int c, input int p, input logic [31:0] d);
      er_t r;
      r.cyc = c; r.port = p; r.data = d;
      exp_rd.push_back(r);
   endtask

   function automatic logic [31:0] memw(input logic [31:0] a);
      return mem[a[11:2]];
   endfunction

   task automatic check_rd(input int p, input logic [31:0] d);
      if (exp_rd.size() == 0) begin
         checks++; errors++;
         $display("FAIL rvalid_unexpected: m%0d rvalid at cycle %0d, required none", p, cyc);
      end else begin
         mon_r = exp_rd.pop_front();
         chk("rvalid_cycle", cyc, mon_r.cyc);
         chk("rvalid_port", p, mon_r.port);
         chk("rdata", d, mon_r.data);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (m0_gnt || m1_gnt) begin
         if (exp_gnt.size() == 0) begin
            checks++; errors++;
            $display("FAIL gnt_unexpected: m0_gnt=%0b m1_gnt=%0b at cycle %0d, required none",
                     m0_gnt, m1_gnt, cyc);
         end else begin
            mon_g = exp_gnt.pop_front();
            chk("gnt_cycle", cyc, mon_g.cyc);
            chk("gnt_port", {31'd0, m1_gnt}, mon_g.port);
            chk("gnt_exclusive", {31'd0, m0_gnt & m1_gnt}, 0);
            chk("gnt_mem_we", {31'd0, mem_we}, {31'd0, mon_g.we});
            chk("gnt_mem_addr", mem_addr, mon_g.addr);
            if (mon_g.we) chk("gnt_mem_wd", mem_wd, mon_g.wd);
         end
      end
      if (m0_rvalid) check_rd(0, m0_rdata);
      if (m1_rvalid) check_rd(1, m1_rdata);
      if (lock_err) begin
         if (exp_lerr.size() == 0) begin
            checks++; errors++;
            $display("FAIL lock_err_unexpected: pulse at cycle %0d, required none", cyc);
         end else begin
            chk("lock_err_cycle", cyc, exp_lerr.pop_front());
         end
      end
   end

   initial begin : drv0
      bit busy;
      busy = 0; d0_req = 0; d0 = '0;
      forever begin
         @(negedge clk);
         if (busy && m0_gnt) busy = 0;
         @(posedge clk);
         #1;
         if (flush0) begin busy = 0; q0.delete(); end
         if (!busy) begin
            if (q0.size() > 0) begin d0 = q0.pop_front(); d0_req = 1; busy = 1; end
            else d0_req = 0;
         end
      end
   end

   initial begin : drv1
      bit busy;
      busy = 0; d1_req = 0; d1 = '0;
      forever begin
         @(negedge clk);
         if (busy && m1_gnt) busy = 0;
         @(posedge clk);
         #1;
         if (flush1) begin busy = 0; q1.delete(); end
         if (!busy) begin
            if (q1.size() > 0) begin d1 = q1.pop_front(); d1_req = 1; busy = 1; end
            else d1_req = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin : main
      int n, n2;
      areset = 1; raw_req = 2'b11; flush0 = 0; flush1 = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      mem[4] = 32'hDEAD_BEEF;

      // reset with both requesting
      repeat (2) begin
         @(negedge clk);
         chk("rst_m0_gnt", {31'd0, m0_gnt}, 0);
         chk("rst_m1_gnt", {31'd0, m1_gnt}, 0);
         chk("rst_mem_we", {31'd0, mem_we}, 0);
         chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 0);
         chk("rst_owner", {30'd0, owner}, 0);
         chk("rst_lock_err", {31'd0, lock_err}, 0);
         chk("rst_rdata", m0_rdata | m1_rdata, 0);
      end
      raw_req = 2'b00; areset = 0;
      repeat (2) @(negedge clk);

      // unlocked write streams alternate, m0 first after reset
      n = cyc + 1;
      for (int i = 0; i < 3; i++) begin
         push(0, 1, 32'h100 + 4*i, 32'hA000_0000 + i, 0);
         push(1, 1, 32'h200 + 4*i, 32'hB000_0000 + i, 0);
         exp_g(n + 1 + 2*i, 0, 1, 32'h100 + 4*i, 32'hA000_0000 + i);
         exp_g(n + 2 + 2*i, 1, 1, 32'h200 + 4*i, 32'hB000_0000 + i);
      end
      repeat (12) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("stream_mem_m0", memw(32'h100 + 4*i), 32'hA000_0000 + i);
         chk("stream_mem_m1", memw(32'h200 + 4*i), 32'hB000_0000 + i);
      end

      // single reads, latency and rdata hold
      @(negedge clk); n = cyc + 1;
      push(0, 0, 32'h10, 32'd0, 0);
      exp_g(n + 1, 0, 0, 32'h10, 32'd0);
      exp_r(n + 2, 0, 32'hDEAD_BEEF);
      repeat (6) @(negedge clk);
      chk("m0_rdata_hold", m0_rdata, 32'hDEAD_BEEF);
      n = cyc + 1;
      push(1, 0, 32'h204, 32'd0, 0);
      exp_g(n + 1, 1, 0, 32'h204, 32'd0);
      exp_r(n + 2, 1, 32'hB000_0001);
      repeat (6) @(negedge clk);
      chk("m1_rdata_hold", m1_rdata, 32'hB000_0001);

      // m1 locked 4-beat burst holds off pending m0
      n = cyc + 1;
      for (int i = 0; i < 4; i++) begin
         push(1, 1, 32'h40 + 4*i, 32'hC000_0000 + i, i < 3);
         exp_g(n + 1 + i, 1, 1, 32'h40 + 4*i, 32'hC000_0000 + i);
      end
      @(negedge clk);
      push(0, 1, 32'h50, 32'h1234_5678, 0);
      exp_g(n + 5, 0, 1, 32'h50, 32'h1234_5678);
      repeat (8) @(negedge clk);
      chk("burst_mem_last", memw(32'h4C), 32'hC000_0003);
      chk("burst_mem_m0", memw(32'h50), 32'h1234_5678);

      // endless lock by m1 with m0 waiting
      n = cyc + 1;
      for (int i = 0; i < 22; i++) push(1, 1, 32'h300 + 4*i, 32'h5000 + i, i < 21);
`ifdef MEM_ARB_TIMEOUT_EN
      for (int i = 0; i < 4; i++) exp_g(n + 1 + i, 1, 1, 32'h300 + 4*i, 32'h5000 + i);
      exp_g(n + 5, 0, 0, 32'h10, 32'd0);
      exp_r(n + 6, 0, 32'hDEAD_BEEF);
      exp_lerr.push_back(n + 5);
      for (int i = 4; i < 22; i++) exp_g(n + 2 + i, 1, 1, 32'h300 + 4*i, 32'h5000 + i);
`else
      for (int i = 0; i < 22; i++) exp_g(n + 1 + i, 1, 1, 32'h300 + 4*i, 32'h5000 + i);
      exp_g(n + 23, 0, 0, 32'h10, 32'd0);
      exp_r(n + 24, 0, 32'hDEAD_BEEF);
`endif
      @(negedge clk);
      push(0, 0, 32'h10, 32'd0, 0);
      while (cyc < n + 5) @(negedge clk);
      chk("timeout_lock_err", {31'd0, lock_err}, {31'd0, EXP_LERR});
      chk("timeout_m0_gnt", {31'd0, m0_gnt}, {31'd0, EXP_LERR});
      repeat (28) @(negedge clk);

      // reset in the middle of a locked m1 burst
      n = cyc + 1;
      for (int i = 0; i < 4; i++) push(1, 1, 32'h500 + 4*i, 32'hE000_0000 + i, i < 3);
      exp_g(n + 1, 1, 1, 32'h500, 32'hE000_0000);
      exp_g(n + 2, 1, 1, 32'h504, 32'hE000_0001);
      while (cyc < n + 2) @(negedge clk);
      @(posedge clk);
      #1 areset = 1;
      @(negedge clk);
      chk("rst_mid_m1_gnt", {31'd0, m1_gnt}, 0);
      chk("rst_mid_mem_we", {31'd0, mem_we}, 0);
      flush1 = 1;
      @(negedge clk);
      chk("rst_mid_owner", {30'd0, owner}, 0);
      chk("rst_mid_we_idle", {31'd0, mem_we}, 0);
      chk("rst_mid_rdata", m0_rdata | m1_rdata, 0);
      flush1 = 0; areset = 0;
      n2 = cyc + 1;
      push(0, 1, 32'h600, 32'h0600_0600, 0);
      push(1, 1, 32'h604, 32'h0604_0604, 0);
      exp_g(n2 + 1, 0, 1, 32'h600, 32'h0600_0600);
      exp_g(n2 + 2, 1, 1, 32'h604, 32'h0604_0604);
      repeat (10) @(negedge clk);
      chk("rst_mid_mem_w1", memw(32'h504), 32'hE000_0001);
      chk("rst_mid_mem_w2", memw(32'h508), 32'd0);
      chk("post_rst_mem_m0", memw(32'h600), 32'h0600_0600);
      chk("post_rst_mem_m1", memw(32'h604), 32'h0604_0604);

      chk("gnt_queue_drained", exp_gnt.size(), 0);
      chk("rd_queue_drained", exp_rd.size(), 0);
      chk("lerr_queue_drained", exp_lerr.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
